// File: rtl/collision_checker_pkg.sv
// ---------------------------------------------------------------------------
// collision_checker_pkg
//   Shared game geometry and state definitions for the collision checker.
//   Holds the obstacle-bus dimensions, the car bounding-box size, the FSM
//   state type and a helper that picks the lowest set bit of a hit mask.
// ---------------------------------------------------------------------------
package collision_checker_pkg;

  localparam int N_OBST          = 6;
  localparam int X_W             = 8;
  localparam int Y_W             = 10;
  localparam int CAR_W           = 16;
  localparam int CAR_H           = 32;
  localparam int HOLD_FRAMES_DEF = 60;
  localparam int IDX_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Walks from the top slot down so the last assignment wins, leaving the
  // lowest set slot; an empty mask yields 0.
  function automatic logic [IDX_W-1:0] lowestSet(input logic [N_OBST-1:0] mask);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_OBST - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/collision_checker_if.sv
// ---------------------------------------------------------------------------
// collision_checker_if
//   Obstacle bus plus the collision result signals.
//   master : the side that drives frame_tick, player position and obstacle
//            slots, and reads the crash/scan results.
//   slave  : the collision checker itself.
//   Signals:
//     frame_tick   1-cycle pulse starting a scan
//     player_x/y   player car left/top edge
//     obstacle_on  per-slot active flags
//     obstacle_x/y packed per-slot coordinates, slot i at [i*W +: W]
//     crash        1-cycle pulse when a scan finds a hit
//     crashed      level, high during crash hold
//     hit_mask     slots that hit in the last scan
//     hit_index    lowest hit slot of the last scan
//     scan_done    1-cycle pulse at the end of every scan
//     overrun      1-cycle pulse when a tick arrives mid-scan
// ---------------------------------------------------------------------------
interface collision_checker_if;
  import collision_checker_pkg::*;

  logic                    frame_tick;
  logic [X_W-1:0]          player_x;
  logic [Y_W-1:0]          player_y;
  logic [N_OBST-1:0]       obstacle_on;
  logic [N_OBST*X_W-1:0]   obstacle_x;
  logic [N_OBST*Y_W-1:0]   obstacle_y;
  logic                    crash;
  logic                    crashed;
  logic [N_OBST-1:0]       hit_mask;
  logic [IDX_W-1:0]        hit_index;
  logic                    scan_done;
  logic                    overrun;

  modport master (
    output frame_tick, player_x, player_y, obstacle_on, obstacle_x, obstacle_y,
    input  crash, crashed, hit_mask, hit_index, scan_done, overrun
  );

  modport slave (
    input  frame_tick, player_x, player_y, obstacle_on, obstacle_x, obstacle_y,
    output crash, crashed, hit_mask, hit_index, scan_done, overrun
  );

endinterface

// File: rtl/collision_checker_box_overlap.sv
// ---------------------------------------------------------------------------
// box_overlap
//   Combinational bounding-box test between one obstacle and the player car.
//   Both boxes are CAR_W x CAR_H pixels.
//   Ports:
//     i_on    obstacle slot active
//     i_objX  obstacle left edge,   i_objY obstacle top edge
//     i_refX  player left edge,     i_refY player top edge
//     o_hit   boxes overlap (touching edges do not count)
// ---------------------------------------------------------------------------
module box_overlap
  import collision_checker_pkg::*;
(
  input  logic           i_on,
  input  logic [X_W-1:0] i_objX,
  input  logic [Y_W-1:0] i_objY,
  input  logic [X_W-1:0] i_refX,
  input  logic [Y_W-1:0] i_refY,
  output logic           o_hit
);

  // Far edges are computed one bit wider than the coordinates so a box near
  // the right/bottom of the field cannot wrap around and fake an overlap.
  logic [X_W:0] w_objRight;
  logic [X_W:0] w_refRight;
  logic [Y_W:0] w_objBottom;
  logic [Y_W:0] w_refBottom;

  assign w_objRight  = {1'b0, i_objX} + (X_W+1)'(CAR_W);
  assign w_refRight  = {1'b0, i_refX} + (X_W+1)'(CAR_W);
  assign w_objBottom = {1'b0, i_objY} + (Y_W+1)'(CAR_H);
  assign w_refBottom = {1'b0, i_refY} + (Y_W+1)'(CAR_H);

  assign o_hit = i_on
               & (w_objRight  > {1'b0, i_refX})
               & (w_refRight  > {1'b0, i_objX})
               & (w_objBottom > {1'b0, i_refY})
               & (w_refBottom > {1'b0, i_objY});

endmodule

// File: rtl/collision_checker.sv
// ---------------------------------------------------------------------------
// collision_checker
//   Reader side of the obstacle bus. On frame_tick it snapshots the player
//   and every obstacle slot, then tests one slot per clock against the
//   player box. A scan with any hit raises crash/crashed and holds for
//   HOLD_FRAMES frame ticks before scanning resumes.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     bus    collision_checker_if.slave (obstacle bus in, results out)
// ---------------------------------------------------------------------------
module collision_checker
  import collision_checker_pkg::*;
#(
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  collision_checker_if.slave  bus
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [N_OBST-1:0]     r_accMask;
  logic [HOLD_W-1:0]     r_holdCnt;

  logic [X_W-1:0]        r_playerX;
  logic [Y_W-1:0]        r_playerY;
  logic [N_OBST-1:0]     r_obsOn;
  logic [N_OBST*X_W-1:0] r_obsX;
  logic [N_OBST*Y_W-1:0] r_obsY;

  logic                  r_crash;
  logic                  r_crashed;
  logic [N_OBST-1:0]     r_hitMask;
  logic [IDX_W-1:0]      r_hitIndex;
  logic                  r_scanDone;
  logic                  r_overrun;

  logic                  w_selOn;
  logic [X_W-1:0]        w_selX;
  logic [Y_W-1:0]        w_selY;
  logic                  w_hit;
  logic [N_OBST-1:0]     w_idxBit;

  // Pick the snapshot slot currently addressed by the scan index so a
  // single overlap checker can be shared across all slots.
  always_comb begin
    w_selOn = 1'b0;
    w_selX  = '0;
    w_selY  = '0;
    for (int i = 0; i < N_OBST; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_selOn = r_obsOn[i];
        w_selX  = r_obsX[i*X_W +: X_W];
        w_selY  = r_obsY[i*Y_W +: Y_W];
      end
    end
  end

  box_overlap u_overlap (
    .i_on   (w_selOn),
    .i_objX (w_selX),
    .i_objY (w_selY),
    .i_refX (r_playerX),
    .i_refY (r_playerY),
    .o_hit  (w_hit)
  );

  assign w_idxBit = N_OBST'(1) << r_idx;

  // Main controller. Pulse outputs default low every cycle and are only
  // raised in the state that owns them. A tick that lands while a scan is
  // still running is dropped and flagged as overrun; ticks during the crash
  // hold only count down the hold and never start a scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_accMask  <= '0;
      r_holdCnt  <= '0;
      r_playerX  <= '0;
      r_playerY  <= '0;
      r_obsOn    <= '0;
      r_obsX     <= '0;
      r_obsY     <= '0;
      r_crash    <= 1'b0;
      r_crashed  <= 1'b0;
      r_hitMask  <= '0;
      r_hitIndex <= '0;
      r_scanDone <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_crash    <= 1'b0;
      r_scanDone <= 1'b0;
      r_overrun  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.frame_tick) begin
            r_playerX <= bus.player_x;
            r_playerY <= bus.player_y;
            r_obsOn   <= bus.obstacle_on;
            r_obsX    <= bus.obstacle_x;
            r_obsY    <= bus.obstacle_y;
            r_idx     <= '0;
            r_accMask <= '0;
            r_state   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (w_hit) r_accMask <= r_accMask | w_idxBit;
          if (bus.frame_tick) r_overrun <= 1'b1;
          if (r_idx == IDX_W'(N_OBST - 1)) begin
            r_state <= ST_REPORT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        ST_REPORT: begin
          r_hitMask  <= r_accMask;
          r_scanDone <= 1'b1;
          if (bus.frame_tick) r_overrun <= 1'b1;
          if (r_accMask != '0) begin
            r_hitIndex <= lowestSet(r_accMask);
            r_crash    <= 1'b1;
            r_crashed  <= 1'b1;
            r_holdCnt  <= HOLD_W'(HOLD_FRAMES);
            r_state    <= ST_HOLD;
          end else begin
            r_hitIndex <= '0;
            r_state    <= ST_IDLE;
          end
        end

        ST_HOLD: begin
          if (bus.frame_tick) begin
            if (r_holdCnt <= HOLD_W'(1)) begin
              r_holdCnt <= '0;
              r_crashed <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_holdCnt <= r_holdCnt - 1'b1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.crash     = r_crash;
  assign bus.crashed   = r_crashed;
  assign bus.hit_mask  = r_hitMask;
  assign bus.hit_index = r_hitIndex;
  assign bus.scan_done = r_scanDone;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_collision_checker.sv
// ---------------------------------------------------------------------------
// tb_collision_checker
//   Directed and randomized checks of collision_checker against a simple
//   integer model of the overlap rules and the scan/hold timing.
// ---------------------------------------------------------------------------
module tb_collision_checker;

  localparam int NS   = 6;
  localparam int HOLD = 60;

  logic clk;
  logic reset;

  collision_checker_if bus ();

  collision_checker #(.HOLD_FRAMES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Scenario as the bench sees it: plain integers per slot.
  int       pX;
  int       pY;
  bit [5:0] on;
  int       oX [NS];
  int       oY [NS];

  // Reference: a slot hits when it is active and the two boxes strictly
  // overlap in both axes, using unbounded integer arithmetic.
  function automatic bit [5:0] refMask();
    bit [5:0] m;
    m = '0;
    for (int i = 0; i < NS; i++) begin
      if (on[i] && (oX[i] + 16 > pX) && (pX + 16 > oX[i]) &&
          (oY[i] + 32 > pY) && (pY + 32 > oY[i]))
        m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int refLowest(input bit [5:0] m);
    for (int i = 0; i < NS; i++) begin
      if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    bus.player_x    = 8'(pX);
    bus.player_y    = 10'(pY);
    bus.obstacle_on = on;
    for (int i = 0; i < NS; i++) begin
      bus.obstacle_x[i*8 +: 8]   = 8'(oX[i]);
      bus.obstacle_y[i*10 +: 10] = 10'(oY[i]);
    end
  endtask

  // Garbage on the bus while a scan runs; only the snapshot may matter.
  task automatic scrambleBus();
    bus.player_x    = 8'($urandom);
    bus.player_y    = 10'($urandom);
    bus.obstacle_on = 6'($urandom);
    bus.obstacle_x  = 48'({$urandom, $urandom});
    bus.obstacle_y  = 60'({$urandom, $urandom});
  endtask

  task automatic clearSlots();
    on = '0;
    for (int i = 0; i < NS; i++) begin
      oX[i] = 0;
      oY[i] = 0;
    end
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raises frame_tick for exactly one sampling edge; returns 1 after it.
  task automatic pulseTick();
    bus.frame_tick = 1'b1;
    stepCycles(1);
    bus.frame_tick = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_crash"},     bus.crash,     0);
    checkOutput({tag, "_crashed"},   bus.crashed,   0);
    checkOutput({tag, "_hitmask"},   bus.hit_mask,  0);
    checkOutput({tag, "_hitindex"},  bus.hit_index, 0);
    checkOutput({tag, "_scandone"},  bus.scan_done, 0);
    checkOutput({tag, "_overrun"},   bus.overrun,   0);
  endtask

  // Full scan: results appear 7 edges after the tick edge and pulses last
  // a single cycle.
  task automatic runScan(input string tag, output bit hit);
    bit [5:0] expMask;
    expMask = refMask();
    hit     = (expMask != 0);
    applyStimulus();
    pulseTick();
    scrambleBus();
    stepCycles(6);
    checkOutput({tag, "_early_done"}, bus.scan_done, 0);
    stepCycles(1);
    checkOutput({tag, "_done"},     bus.scan_done, 1);
    checkOutput({tag, "_crash"},    bus.crash,     32'(hit));
    checkOutput({tag, "_crashed"},  bus.crashed,   32'(hit));
    checkOutput({tag, "_hitmask"},  bus.hit_mask,  32'(expMask));
    checkOutput({tag, "_hitindex"}, bus.hit_index, 32'(refLowest(expMask)));
    checkOutput({tag, "_overrun"},  bus.overrun,   0);
    stepCycles(1);
    checkOutput({tag, "_crash_pulse"}, bus.crash,     0);
    checkOutput({tag, "_done_pulse"},  bus.scan_done, 0);
    applyStimulus();
  endtask

  // Counts the hold down; crashed must fall on exactly the last tick and
  // that tick must not start a scan.
  task automatic drainHold(input string tag, input bit checkEach);
    for (int t = 1; t <= HOLD; t++) begin
      pulseTick();
      if (t == HOLD) begin
        checkOutput({tag, "_hold_end"}, bus.crashed, 0);
        stepCycles(7);
        checkOutput({tag, "_hold_noscan"}, bus.scan_done, 0);
      end else begin
        if (checkEach) begin
          checkOutput({tag, "_hold_crashed"}, bus.crashed, 1);
          checkOutput({tag, "_hold_overrun"}, bus.overrun, 0);
        end
        stepCycles(2);
      end
    end
  endtask

  initial begin
    bit       hit;
    bit [5:0] expMask;
    int       tmp;

    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    pX = 0; pY = 0;
    clearSlots();
    applyStimulus();
    stepCycles(3);
    checkAllZero("reset");
    reset = 1'b0;
    stepCycles(2);

    // Single overlapping slot
    pX = 100; pY = 400;
    clearSlots();
    on[2] = 1'b1; oX[2] = 110; oY[2] = 420;
    runScan("t1", hit);
    checkOutput("t1_model_hit", 32'(hit), 1);
    // Hold countdown, then the following tick scans again
    drainHold("t4", 1'b1);
    runScan("t4_rescan", hit);
    if (hit) drainHold("t4_rescan", 1'b0);

    // Touching edge and inactive slot do not hit
    clearSlots();
    on[0] = 1'b1; oX[0] = 116; oY[0] = 400;
    on[1] = 1'b0; oX[1] = 100; oY[1] = 400;
    runScan("t2", hit);

    // Two overlapping slots, lowest one reported
    clearSlots();
    on[1] = 1'b1; oX[1] = 105; oY[1] = 410;
    on[4] = 1'b1; oX[4] = 90;  oY[4] = 380;
    runScan("t3", hit);
    if (hit) drainHold("t3", 1'b0);

    // Tick during scan: overrun pulse, scan result unaffected
    clearSlots();
    on[3] = 1'b1; oX[3] = 95; oY[3] = 390;
    on[5] = 1'b1; oX[5] = 10; oY[5] = 10;
    expMask = refMask();
    applyStimulus();
    pulseTick();
    scrambleBus();
    stepCycles(2);
    pulseTick();
    checkOutput("t5_overrun", bus.overrun, 1);
    stepCycles(1);
    checkOutput("t5_overrun_pulse", bus.overrun, 0);
    stepCycles(3);
    checkOutput("t5_done",     bus.scan_done, 1);
    checkOutput("t5_hitmask",  bus.hit_mask,  32'(expMask));
    checkOutput("t5_hitindex", bus.hit_index, 32'(refLowest(expMask)));
    checkOutput("t5_crash",    bus.crash,     32'(expMask != 0));
    applyStimulus();
    if (expMask != 0) drainHold("t5", 1'b0);

    // Reset in the middle of a hitting scan
    clearSlots();
    on[2] = 1'b1; oX[2] = 110; oY[2] = 420;
    applyStimulus();
    pulseTick();
    stepCycles(3);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkAllZero("t6_reset");
    stepCycles(3);
    checkOutput("t6_no_crash", bus.crash,     0);
    checkOutput("t6_no_done",  bus.scan_done, 0);
    runScan("t6_after", hit);

    // Reset during the crash hold
    stepCycles(3);
    pulseTick();
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkAllZero("t6_holdreset");
    clearSlots();
    runScan("t6_idle_scan", hit);

    // Far-edge coordinates must not wrap into a hit
    pX = 250; pY = 1010;
    clearSlots();
    on[0] = 1'b1; oX[0] = 5;   oY[0] = 1000;
    on[1] = 1'b1; oX[1] = 245; oY[1] = 5;
    on[2] = 1'b1; oX[2] = 240; oY[2] = 1000;
    runScan("extra_wrap", hit);
    if (hit) drainHold("extra_wrap", 1'b0);

    // Randomized scenarios with obstacles clustered around the player
    for (int r = 0; r < 8; r++) begin
      pX = int'($urandom_range(0, 255));
      pY = int'($urandom_range(0, 1023));
      on = 6'($urandom);
      for (int i = 0; i < NS; i++) begin
        tmp = pX + int'($urandom_range(0, 40)) - 20;
        oX[i] = (tmp < 0) ? 0 : ((tmp > 255) ? 255 : tmp);
        tmp = pY + int'($urandom_range(0, 80)) - 40;
        oY[i] = (tmp < 0) ? 0 : ((tmp > 1023) ? 1023 : tmp);
      end
      runScan("rand", hit);
      if (hit) drainHold("rand", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
